window_buffer_3x3: RTL and testbench
====================================

WINDOW_BUFFER_3X3 -- requirements
Module: window_buffer_3x3

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning maximum pixels per active line and depth of each line memory.
REQ-002 SHALL have parameter PIXEL_W, default 8, meaning pixel width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low: rst=0 at a rising clk edge resets the block.
REQ-005 SHALL have port pixel_in  input  PIXEL_W  grayscale pixel, valid when de=1.
REQ-006 SHALL have ports hsync, vsync, de  input  1 each  video timing; de=1 marks active pixels.
REQ-007 SHALL have ports pixel_out1..pixel_out9  output  PIXEL_W each  3x3 window, row-major: 1-3 top, 4-6 middle, 7-9 bottom, left to right.
REQ-008 SHALL have ports hsync_out, vsync_out, de_out  output  1 each  timing delayed to match the window.

Function
REQ-009 SHALL store the two most recent completed lines in two H_ACTIVE-deep line memories with registered read, read-before-write at the same address.
REQ-010 SHALL keep a column counter col: cleared on reset and on each de falling edge, incremented per de=1 cycle, saturating at H_ACTIVE.
REQ-011 SHALL keep a line counter lines (0..2, saturating): cleared on reset and on a vsync rising edge, incremented on each de falling edge.
REQ-012 SHALL, on a de=1 cycle with col<H_ACTIVE, read then write both memories at address col: newer memory <= pixel_in, older memory <= newer memory's previous content.
REQ-013 SHALL NOT write memories when col=H_ACTIVE; surplus pixels still enter the bottom row, top/middle rows read 0.
REQ-014 SHALL have fixed latency 2 cycles: input de=1 at cycle k with pixel P(r,c) produces de_out=1 at cycle k+2 with pixel_out9=P(r,c), pixel_out8=P(r,c-1), pixel_out7=P(r,c-2), pixel_out6/5/4=P(r-1,c..c-2), pixel_out3/2/1=P(r-2,c..c-2).
REQ-015 SHALL output 0 for any window position with c-n<0 (column shift registers cleared on each de rising edge).
REQ-016 SHALL output 0 for the middle row when lines<1 and for the top row when lines<2 (masking, no memory clear).
REQ-017 SHALL shift the window only on de=1 cycles; on de=0 cycles pixel_out1..9 hold their last values.
REQ-018 SHALL delay hsync, vsync, de by exactly 2 cycles via shift registers to hsync_out, vsync_out, de_out.
REQ-019 SHALL give a coincident vsync rising edge and de falling edge priority to vsync (lines becomes 0).
REQ-020 SHALL hold all arithmetic unsigned; counters sized ceil(log2(H_ACTIVE+1)) and 2 bits.

Reset
REQ-021 SHALL, while rst=0, drive pixel_out1..9, hsync_out, vsync_out, de_out to 0 and clear col, lines, window and delay registers.
REQ-022 SHALL NOT clear line memories on reset; stale contents are masked per REQ-016.
REQ-023 SHALL, on reset deasserted mid-line, treat remaining de=1 pixels as line 0, column 0 of a new frame; first valid output 2 cycles after the first de=1 cycle following reset.

Verification
REQ-024 Reset: rst=0 for 3 cycles with random inputs -> all outputs 0; after release with idle inputs, outputs remain 0.
REQ-025 Latency/sync: single pulse hsync=1, vsync=1, de=1 at cycle 10 -> same pulses on outputs at cycle 12 only.
REQ-026 First lines: H_ACTIVE=8, vsync pulse, line 0 pixels 1..8 -> at pixel 8 output pixel_out7/8/9=6/7/8, pixel_out1..6=0; line 1 pixels 11..18 -> at pixel 18 middle row 6/7/8, bottom 16/17/18, top 0.
REQ-027 Steady state: H_ACTIVE=8, lines of value 10*row+col -> row 4 col 5 gives top 23/24/25, middle 33/34/35, bottom 43/44/45; line start col 0 gives pixel_out1,2,4,5,7,8=0.
REQ-028 Overflow and de gaps: 10 pixels on an H_ACTIVE=8 line, de=0 for 3 cycles mid-line -> memories hold only first 8, windows hold during gaps, next line middle row shows pixels 1..8.
REQ-029 Frame restart: vsync coincident with de falling edge after line 5 -> next line outputs top and middle rows 0.

Source files
------------

// File: rtl/window_buffer_3x3.sv
// window_buffer_3x3: 3x3 pixel window over a raster stream using two line memories.
// Window and timing both run two cycles behind the input.
module window_buffer_3x3 #(
  parameter int H_ACTIVE = 640,
  parameter int PIXEL_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               de,
  output logic [PIXEL_W-1:0] pixel_out1,
  output logic [PIXEL_W-1:0] pixel_out2,
  output logic [PIXEL_W-1:0] pixel_out3,
  output logic [PIXEL_W-1:0] pixel_out4,
  output logic [PIXEL_W-1:0] pixel_out5,
  output logic [PIXEL_W-1:0] pixel_out6,
  output logic [PIXEL_W-1:0] pixel_out7,
  output logic [PIXEL_W-1:0] pixel_out8,
  output logic [PIXEL_W-1:0] pixel_out9,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de_out
);
  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int AW = $clog2(H_ACTIVE);
  logic [PIXEL_W-1:0] mem_new [H_ACTIVE];
  logic [PIXEL_W-1:0] mem_old [H_ACTIVE];
  logic [CW-1:0]      col;
  logic [AW-1:0]      addr;
  logic [1:0]         lines;
  logic               de_d, vs_d, wr, de_fall, first;
  logic [PIXEL_W-1:0] rd_new, rd_old, pix1;
  logic [2:0]         sync1, sync2;
  logic [PIXEL_W-1:0] w [9];
  assign addr    = col[AW-1:0];
  assign wr      = rst && de && (col != CW'(H_ACTIVE));
  assign de_fall = de_d && !de;
  assign first   = sync1[0] && !sync2[0];
  always_ff @(posedge clk)
    if (wr) begin
      mem_new[addr] <= pixel_in;
      mem_old[addr] <= mem_new[addr];
    end
  always_ff @(posedge clk) begin
    if (!rst) begin
      col    <= '0;
      lines  <= '0;
      de_d   <= 1'b0;
      vs_d   <= 1'b0;
      rd_new <= '0;
      rd_old <= '0;
      pix1   <= '0;
      sync1  <= '0;
      sync2  <= '0;
      for (int i = 0; i < 9; i++) w[i] <= '0;
    end else begin
      de_d  <= de;
      vs_d  <= vsync;
      col   <= de_fall ? '0 : (de && col != CW'(H_ACTIVE)) ? col + CW'(1) : col;
      // vsync rising edge wins over a coincident end of line
      lines <= (vsync && !vs_d) ? 2'd0 : (de_fall && lines != 2'd2) ? lines + 2'd1 : lines;
      sync1 <= {hsync, vsync, de};
      sync2 <= sync1;
      if (de) begin
        rd_new <= (wr && lines != 2'd0) ? mem_new[addr] : '0;
        rd_old <= (wr && lines == 2'd2) ? mem_old[addr] : '0;
        pix1   <= pixel_in;
      end
      if (sync1[0]) begin
        for (int r = 0; r < 3; r++) begin
          w[3*r]   <= first ? '0 : w[3*r+1];
          w[3*r+1] <= first ? '0 : w[3*r+2];
        end
        w[2] <= rd_old;
        w[5] <= rd_new;
        w[8] <= pix1;
      end
    end
  end
  assign pixel_out1 = w[0];
  assign pixel_out2 = w[1];
  assign pixel_out3 = w[2];
  assign pixel_out4 = w[3];
  assign pixel_out5 = w[4];
  assign pixel_out6 = w[5];
  assign pixel_out7 = w[6];
  assign pixel_out8 = w[7];
  assign pixel_out9 = w[8];
  assign {hsync_out, vsync_out, de_out} = sync2;
endmodule

// File: tb/tb_window_buffer_3x3.sv
// tb_window_buffer_3x3: directed checks of the 3x3 window buffer with H_ACTIVE=8.
module tb_window_buffer_3x3;
  logic clk = 1'b0, rst = 1'b0, hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic [7:0] pixel_in = '0;
  logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8, o9;
  logic hsync_out, vsync_out, de_out;
  int ncmp = 0, nbad = 0;
  logic [71:0] cap [0:15][0:11];
  int crow = 0, ccol = 0;
  logic prev_de = 1'b0;
  typedef struct {
    string       name;
    int          row;
    int          col;
    logic [71:0] exp;
  } chk_t;
  chk_t tbl [12];
  window_buffer_3x3 #(.H_ACTIVE(8), .PIXEL_W(8)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .hsync(hsync), .vsync(vsync), .de(de),
    .pixel_out1(o1), .pixel_out2(o2), .pixel_out3(o3), .pixel_out4(o4), .pixel_out5(o5),
    .pixel_out6(o6), .pixel_out7(o7), .pixel_out8(o8), .pixel_out9(o9),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );
  always #5 clk = ~clk;
  function automatic logic [71:0] win();
    return {o1, o2, o3, o4, o5, o6, o7, o8, o9};
  endfunction
  function automatic logic [71:0] w9(input int a, b, c, d, e, f, g, h, i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction
  always @(negedge clk) begin
    if (de_out) begin
      if (crow < 16 && ccol < 12) cap[crow][ccol] = win();
      ccol++;
    end else if (prev_de) begin
      crow++;
      ccol = 0;
    end
    prev_de = de_out;
  end
  task automatic chk(input string n, input logic [71:0] got, input logic [71:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", n, got, exp);
    end
  endtask
  task automatic tick(input logic h, input logic v, input logic d, input logic [7:0] p);
    hsync = h; vsync = v; de = d; pixel_in = p;
    @(negedge clk);
  endtask
  task automatic line(input int base, input int n);
    tick(1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    for (int c = 0; c < n; c++) tick(0, 0, 1, 8'(base + c));
  endtask
  initial begin
    tbl[0]  = '{"r0c7",    1, 7, w9(0, 0, 0, 0, 0, 0, 5, 6, 7)};
    tbl[1]  = '{"r1c7",    2, 7, w9(0, 0, 0, 5, 6, 7, 15, 16, 17)};
    tbl[2]  = '{"r2c1",    3, 1, w9(0, 0, 1, 0, 10, 11, 0, 20, 21)};
    tbl[3]  = '{"r3c7",    4, 7, w9(15, 16, 17, 25, 26, 27, 35, 36, 37)};
    tbl[4]  = '{"r4c5",    5, 5, w9(23, 24, 25, 33, 34, 35, 43, 44, 45)};
    tbl[5]  = '{"r4c0",    5, 0, w9(0, 0, 20, 0, 0, 30, 0, 0, 40)};
    tbl[6]  = '{"r5c8",    6, 8, w9(36, 37, 0, 46, 47, 0, 56, 57, 58)};
    tbl[7]  = '{"r5c9",    6, 9, w9(37, 0, 0, 47, 0, 0, 57, 58, 59)};
    tbl[8]  = '{"r6c7",    7, 7, w9(45, 46, 47, 55, 56, 57, 65, 66, 67)};
    tbl[9]  = '{"r6c1",    7, 1, w9(0, 40, 41, 0, 50, 51, 0, 60, 61)};
    tbl[10] = '{"restart", 8, 7, w9(0, 0, 0, 0, 0, 0, 75, 76, 77)};
    tbl[11] = '{"rst_c0",  8, 0, w9(0, 0, 0, 0, 0, 0, 0, 0, 70)};
    // reset with random inputs, then idle after release
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      chk("reset", {win(), hsync_out, vsync_out, de_out}, '0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0);
      chk("idle", {win(), hsync_out, vsync_out, de_out}, '0);
    end
    // single sync/de pulse must reappear exactly two cycles later
    for (int i = 0; i < 16; i++) begin
      chk("latency", {69'd0, hsync_out, vsync_out, de_out}, (i == 12) ? 72'd7 : 72'd0);
      if (i == 12) chk("lat_pix", {64'd0, o9}, 72'h55);
      tick(i == 10, i == 10, i == 10, (i == 10) ? 8'h55 : 8'h00);
    end
    tick(0, 1, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    for (int r = 0; r < 7; r++) line(10 * r, (r == 5) ? 10 : 8);
    // frame restart: vsync rises on the same cycle de falls
    tick(0, 1, 0, 0);
    line(70, 8);
    line(80, 4);
    begin
      int holds = 0;
      logic seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (i < 3) tick(0, 0, 0, 0);
        else tick(0, 0, 1, 8'(84 + i - 3));
        if (!de_out) begin
          holds++;
          chk("gap_hold", win(), w9(0, 0, 0, 71, 72, 73, 81, 82, 83));
        end else if (holds > 0 && !seen) begin
          seen = 1'b1;
          chk("after_gap", win(), w9(0, 0, 70, 0, 0, 80, 0, 0, 84));
        end
      end
      chk("hold_count", 72'(holds), 72'd3);
    end
    repeat (6) tick(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) chk(tbl[i].name, cap[tbl[i].row][tbl[i].col], tbl[i].exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
